// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int DATA_W = 32;

  // Loader phases: accept words, hold the core in reset, run, or stuck on overflow
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Program loader: streams instruction words into instruction memory starting at
// word 0, keeps the core in reset while loading, and releases it a fixed number
// of cycles after the final word has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter  int IMEM_DEPTH    = 256,
  parameter  int RELEASE_DELAY = 2,
  localparam int ADDR_W        = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int DLY_W = $clog2(RELEASE_DELAY + 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(RELEASE_DELAY);

  loader_state_e r_state;
  loader_state_e w_next;

  logic              w_ready;
  logic              w_hs;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DLY_W-1:0]  r_delay;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_core_rst_n;
  logic              r_load_done;
  logic              r_overflow;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; reload overrides everything and restarts the load
  always_comb begin
    w_next = r_state;
    if (reload) begin
      w_next = LOAD;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_hs && s_last) begin
            w_next = HOLD;
          end else if (w_hs && (r_ptr == PTR_LAST)) begin
            w_next = ERR;
          end
        end
        HOLD: begin
          if (r_delay == DLY_LAST) begin
            w_next = RUN;
          end
        end
        RUN:     w_next = RUN;
        ERR:     w_next = ERR;
        default: w_next = LOAD;
      endcase
    end
  end

  // Ready decodes from state and reload only, never from s_valid
  always_comb begin
    w_ready = (r_state == LOAD) && !reload;
    w_hs    = s_valid && w_ready;
  end

  // Write port, pointer, counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_count      <= '0;
      r_delay      <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_rst_n <= 1'b0;
      r_load_done  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_we <= w_hs;
      if (w_hs) begin
        r_addr  <= r_ptr;
        r_wdata <= s_data;
      end
      if (reload) begin
        r_ptr   <= '0;
        r_count <= '0;
        r_delay <= '0;
      end else begin
        if (w_hs) begin
          r_ptr   <= r_ptr + ADDR_W'(1);
          r_count <= r_count + (ADDR_W + 1)'(1);
        end
        if ((r_state == HOLD) && (r_delay != DLY_LAST)) begin
          r_delay <= r_delay + DLY_W'(1);
        end
      end
      r_core_rst_n <= (w_next == RUN);
      r_load_done  <= (w_next == RUN);
      r_overflow   <= (w_next == ERR);
    end
  end

  assign s_ready    = w_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_rst_n = r_core_rst_n;
  assign load_done  = r_load_done;
  assign overflow   = r_overflow;
  assign word_count = r_count;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a full-size loader and a 4-word loader, each with a
// behavioural instruction memory, checked against expected memory images.
module tb_imem_loader;

  localparam int RD = 2;

  logic        clk = 1'b0;
  logic        rstN;
  logic        sValid;
  logic [31:0] sData;
  logic        sLast;
  logic        reload;
  logic        useSmall;

  logic vM, vS, rlM, rlS;
  assign vM  = sValid & ~useSmall;
  assign vS  = sValid & useSmall;
  assign rlM = reload & ~useSmall;
  assign rlS = reload & useSmall;

  logic        sReadyM, weM, coreRstNM, loadDoneM, overflowM;
  logic [7:0]  addrM;
  logic [31:0] wdataM;
  logic [8:0]  wcM;

  logic        sReadyS, weS, coreRstNS, loadDoneS, overflowS;
  logic [1:0]  addrS;
  logic [31:0] wdataS;
  logic [2:0]  wcS;

  logic [31:0] capM [256];
  logic [31:0] refM [256];
  logic [31:0] capS [4];
  logic [31:0] refS [4];
  int weCountM = 0;
  int weCountS = 0;

  int checks = 0;
  int errors = 0;

  imem_loader #(.IMEM_DEPTH(256), .RELEASE_DELAY(RD)) dut (
    .clk(clk), .rst_n(rstN), .s_valid(vM), .s_ready(sReadyM), .s_data(sData),
    .s_last(sLast), .reload(rlM), .imem_we(weM), .imem_addr(addrM),
    .imem_wdata(wdataM), .core_rst_n(coreRstNM), .load_done(loadDoneM),
    .overflow(overflowM), .word_count(wcM)
  );

  imem_loader #(.IMEM_DEPTH(4), .RELEASE_DELAY(RD)) dutSmall (
    .clk(clk), .rst_n(rstN), .s_valid(vS), .s_ready(sReadyS), .s_data(sData),
    .s_last(sLast), .reload(rlS), .imem_we(weS), .imem_addr(addrS),
    .imem_wdata(wdataS), .core_rst_n(coreRstNS), .load_done(loadDoneS),
    .overflow(overflowS), .word_count(wcS)
  );

  always #5 clk = ~clk;

  // Instruction memories capture mid-cycle while the write enable is high
  always @(negedge clk) begin
    if (weM) begin
      capM[addrM] = wdataM;
      weCountM++;
    end
    if (weS) begin
      capS[addrS] = wdataS;
      weCountS++;
    end
  end

  // Stream n random words; the k-th accepted word belongs at address k
  task automatic applyStimulus(input int n, input bit withLast, input int gapPct,
                               output int accepted, output int cycles);
    int waitCnt;
    bit done;
    logic [31:0] word;
    accepted = 0;
    cycles = 0;
    for (int i = 0; i < n; i++) begin
      word = $urandom;
      done = 1'b0;
      waitCnt = 0;
      while (!done && waitCnt < 40) begin
        @(negedge clk);
        sValid = ($urandom_range(99) >= gapPct);
        sData  = word;
        sLast  = withLast && (i == n - 1);
        #1;
        if (sValid && (useSmall ? sReadyS : sReadyM)) begin
          done = 1'b1;
          if (useSmall) begin
            if (accepted < 4) refS[accepted] = word;
          end else begin
            if (accepted < 256) refM[accepted] = word;
          end
          accepted++;
        end
        @(posedge clk);
        cycles++;
        waitCnt++;
      end
      if (!done) break;
    end
    @(negedge clk);
    sValid = 1'b0;
    sLast  = 1'b0;
    #1;
  endtask

  // Single-cycle reload pulse; returns just after the sampling edge
  task automatic pulseReload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (weM !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b expected 0", weM); end
    checks++; if (addrM !== 8'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", addrM); end
    checks++; if (wdataM !== 32'd0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", wdataM); end
    checks++; if (coreRstNM !== 1'b0) begin errors++; $display("[TB] FAIL reset_core_rst_n: got %b expected 0", coreRstNM); end
    checks++; if (loadDoneM !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_done: got %b expected 0", loadDoneM); end
    checks++; if (overflowM !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflowM); end
    checks++; if (wcM !== 9'd0) begin errors++; $display("[TB] FAIL reset_word_count: got %0d expected 0", wcM); end
    checks++; if (sReadyM !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready: got %b expected 1", sReadyM); end
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (coreRstNM !== 1'b0) begin errors++; $display("[TB] FAIL idle_core_rst_n: got %b expected 0", coreRstNM); end
  endtask

  task automatic test_back_to_back();
    int acc, cyc, we0, bad;
    we0 = weCountM;
    applyStimulus(22, 1'b1, 0, acc, cyc);
    checks++; if (acc != 22) begin errors++; $display("[TB] FAIL b2b_accepted: got %0d expected 22", acc); end
    checks++; if (cyc != 22) begin errors++; $display("[TB] FAIL b2b_cycles: got %0d expected 22", cyc); end
    checks++; if (sReadyM !== 1'b0) begin errors++; $display("[TB] FAIL b2b_hold_ready: got %b expected 0", sReadyM); end
    checks++; if (coreRstNM !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rel_edge0: got %b expected 0", coreRstNM); end
    for (int j = 1; j <= RD + 1; j++) begin
      @(negedge clk);
      #1;
      checks++;
      if (coreRstNM !== (j == RD + 1)) begin
        errors++;
        $display("[TB] FAIL b2b_release_edge%0d: got %b expected %b", j, coreRstNM, (j == RD + 1));
      end
    end
    checks++; if (loadDoneM !== 1'b1) begin errors++; $display("[TB] FAIL b2b_load_done: got %b expected 1", loadDoneM); end
    checks++; if (wcM !== 9'd22) begin errors++; $display("[TB] FAIL b2b_word_count: got %0d expected 22", wcM); end
    checks++; if (weCountM - we0 != 22) begin errors++; $display("[TB] FAIL b2b_we_pulses: got %0d expected 22", weCountM - we0); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (capM[i] !== refM[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL b2b_memory: got %0d bad words expected 0", bad); end
  endtask

  task automatic test_reload_run();
    int acc, cyc, bad;
    pulseReload();
    checks++; if (coreRstNM !== 1'b0) begin errors++; $display("[TB] FAIL rl_core_rst_n: got %b expected 0", coreRstNM); end
    checks++; if (loadDoneM !== 1'b0) begin errors++; $display("[TB] FAIL rl_load_done: got %b expected 0", loadDoneM); end
    checks++; if (sReadyM !== 1'b1) begin errors++; $display("[TB] FAIL rl_s_ready: got %b expected 1", sReadyM); end
    checks++; if (wcM !== 9'd0) begin errors++; $display("[TB] FAIL rl_word_count: got %0d expected 0", wcM); end
    applyStimulus(3, 1'b1, 0, acc, cyc);
    repeat (RD + 1) @(negedge clk);
    #1;
    checks++; if (loadDoneM !== 1'b1) begin errors++; $display("[TB] FAIL rl_rerun: got %b expected 1", loadDoneM); end
    checks++; if (wcM !== 9'd3) begin errors++; $display("[TB] FAIL rl_word_count3: got %0d expected 3", wcM); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (capM[i] !== refM[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL rl_memory: got %0d bad words expected 0", bad); end
  endtask

  task automatic test_gaps();
    int acc, cyc, we0, bad;
    pulseReload();
    we0 = weCountM;
    applyStimulus(8, 1'b1, 50, acc, cyc);
    repeat (RD + 1) @(negedge clk);
    #1;
    checks++; if (acc != 8) begin errors++; $display("[TB] FAIL gap_accepted: got %0d expected 8", acc); end
    checks++; if (weCountM - we0 != 8) begin errors++; $display("[TB] FAIL gap_we_pulses: got %0d expected 8", weCountM - we0); end
    checks++; if (wcM !== 9'd8) begin errors++; $display("[TB] FAIL gap_word_count: got %0d expected 8", wcM); end
    checks++; if (loadDoneM !== 1'b1) begin errors++; $display("[TB] FAIL gap_load_done: got %b expected 1", loadDoneM); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (capM[i] !== refM[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL gap_memory: got %0d bad words expected 0", bad); end
  endtask

  task automatic test_reload_collision();
    int acc, cyc, we0, bad;
    pulseReload();
    applyStimulus(2, 1'b0, 0, acc, cyc);
    @(negedge clk);
    sValid = 1'b1;
    sData  = 32'hDEADBEEF;
    sLast  = 1'b0;
    reload = 1'b1;
    #1;
    checks++; if (sReadyM !== 1'b0) begin errors++; $display("[TB] FAIL col_ready_forced: got %b expected 0", sReadyM); end
    we0 = weCountM;
    @(negedge clk);
    reload = 1'b0;
    sValid = 1'b0;
    #1;
    checks++; if (weM !== 1'b0) begin errors++; $display("[TB] FAIL col_no_write: got %b expected 0", weM); end
    checks++; if (wcM !== 9'd0) begin errors++; $display("[TB] FAIL col_word_count: got %0d expected 0", wcM); end
    checks++; if (weCountM != we0) begin errors++; $display("[TB] FAIL col_we_pulses: got %0d expected %0d", weCountM, we0); end
    applyStimulus(1, 1'b1, 0, acc, cyc);
    checks++; if (addrM !== 8'd0) begin errors++; $display("[TB] FAIL col_next_addr: got %0d expected 0", addrM); end
    repeat (RD + 1) @(negedge clk);
    #1;
    checks++; if (loadDoneM !== 1'b1) begin errors++; $display("[TB] FAIL col_one_word_run: got %b expected 1", loadDoneM); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (capM[i] !== refM[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL col_memory: got %0d bad words expected 0", bad); end
  endtask

  task automatic test_reset_midload();
    int acc, cyc, bad;
    pulseReload();
    applyStimulus(3, 1'b0, 0, acc, cyc);
    #2;
    rstN = 1'b0;
    #1;
    checks++; if (weM !== 1'b0 || addrM !== 8'd0 || wdataM !== 32'd0) begin
      errors++; $display("[TB] FAIL mid_write_port: got we=%b addr=%h data=%h expected all 0", weM, addrM, wdataM);
    end
    checks++; if (coreRstNM !== 1'b0 || loadDoneM !== 1'b0 || overflowM !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_status: got crst=%b done=%b ovf=%b expected 0 0 0", coreRstNM, loadDoneM, overflowM);
    end
    checks++; if (wcM !== 9'd0 || sReadyM !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_count_ready: got wc=%0d rdy=%b expected 0 1", wcM, sReadyM);
    end
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(6, 1'b1, 20, acc, cyc);
    repeat (RD + 1) @(negedge clk);
    #1;
    checks++; if (coreRstNM !== 1'b1) begin errors++; $display("[TB] FAIL mid_release: got %b expected 1", coreRstNM); end
    checks++; if (wcM !== 9'd6) begin errors++; $display("[TB] FAIL mid_word_count: got %0d expected 6", wcM); end
    bad = 0;
    for (int i = 0; i < 256; i++) if (capM[i] !== refM[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL mid_memory: got %0d bad words expected 0", bad); end
  endtask

  task automatic test_overflow();
    int acc, cyc, bad;
    useSmall = 1'b1;
    applyStimulus(5, 1'b0, 0, acc, cyc);
    checks++; if (acc != 4) begin errors++; $display("[TB] FAIL ovf_accepted: got %0d expected 4", acc); end
    checks++; if (overflowS !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflowS); end
    checks++; if (sReadyS !== 1'b0) begin errors++; $display("[TB] FAIL ovf_ready: got %b expected 0", sReadyS); end
    checks++; if (wcS !== 3'd4) begin errors++; $display("[TB] FAIL ovf_word_count: got %0d expected 4", wcS); end
    checks++; if (weCountS != 4) begin errors++; $display("[TB] FAIL ovf_we_pulses: got %0d expected 4", weCountS); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (coreRstNS !== 1'b0 || overflowS !== 1'b1) begin
      errors++; $display("[TB] FAIL ovf_sticky: got crst=%b ovf=%b expected 0 1", coreRstNS, overflowS);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) if (capS[i] !== refS[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL ovf_memory: got %0d bad words expected 0", bad); end
    pulseReload();
    checks++; if (overflowS !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared: got %b expected 0", overflowS); end
    checks++; if (sReadyS !== 1'b1) begin errors++; $display("[TB] FAIL ovf_reload_ready: got %b expected 1", sReadyS); end
    applyStimulus(4, 1'b1, 0, acc, cyc);
    repeat (RD + 1) @(negedge clk);
    #1;
    checks++; if (overflowS !== 1'b0 || loadDoneS !== 1'b1) begin
      errors++; $display("[TB] FAIL full_depth_last: got ovf=%b done=%b expected 0 1", overflowS, loadDoneS);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) if (capS[i] !== refS[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL full_depth_memory: got %0d bad words expected 0", bad); end
    useSmall = 1'b0;
  endtask

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence
  initial begin
    sValid = 1'b0;
    sData = 32'd0;
    sLast = 1'b0;
    reload = 1'b0;
    useSmall = 1'b0;
    rstN = 1'b0;
    for (int i = 0; i < 256; i++) begin
      capM[i] = 32'd0;
      refM[i] = 32'd0;
    end
    for (int i = 0; i < 4; i++) begin
      capS[i] = 32'd0;
      refS[i] = 32'd0;
    end
    test_reset();
    test_back_to_back();
    test_reload_run();
    test_gaps();
    test_reload_collision();
    test_reset_midload();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader sitting directly upstream of `core`. It accepts a stream of 32-bit instruction words over a valid/ready interface and writes them into the core's instruction memory, starting at word 0. While loading it holds the core in reset, then releases it after a fixed delay. It replaces the bench-time preload of instruction memory, so the same program images can be driven in simulation and on hardware.

## Interface
- `IMEM_DEPTH`, 256: instruction memory depth in 32-bit words; power of two, ≥ 4.
- `RELEASE_DELAY`, 2: cycles the core stays in reset after the last word is written; ≥ 1.
- `ADDR_W`, $clog2(IMEM_DEPTH): local parameter; word-address width.

- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  32  instruction word.
- `s_last`  in  1  marks the final word of the program.
- `reload`  in  1  single-cycle pulse; restarts loading from word 0.
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  ADDR_W  word index (byte address / 4).
- `imem_wdata`  out  32  write data.
- `core_rst_n`  out  1  registered active-low reset to `core`.
- `load_done`  out  1  high while the core is running a loaded program.
- `overflow`  out  1  sticky; the program exceeded IMEM_DEPTH.
- `word_count`  out  ADDR_W+1  number of words accepted in the current load.

## Operation
- State machine states: LOAD, HOLD, RUN, ERR.
- Reset values:
  - state = LOAD.
  - write pointer = 0, word_count = 0, delay counter = 0.
  - imem_we = 0, imem_addr = 0, imem_wdata = 0.
  - core_rst_n = 0, load_done = 0, overflow = 0.
- LOAD:
  - `s_ready` = 1. A handshake is `s_valid & s_ready`.
  - Each handshake registers (we=1, addr=ptr, wdata=s_data), then increments ptr and word_count.
  - Handshake with `s_last` goes to HOLD.
  - Handshake at ptr = IMEM_DEPTH-1 without `s_last`: that word is still written, then the machine goes to ERR and sets `overflow`.
  - `s_last` at ptr = IMEM_DEPTH-1 is legal and goes to HOLD.
- HOLD:
  - `s_ready` = 0; `core_rst_n` = 0.
  - The delay counter counts RELEASE_DELAY cycles, then goes to RUN.
- RUN: `s_ready` = 0, `core_rst_n` = 1, `load_done` = 1.
- ERR: `s_ready` = 0, `core_rst_n` = 0, `overflow` = 1. Exits only on `reload` or `rst_n`.
- `reload` from any state:
  - Next state LOAD; ptr, word_count and delay counter go to 0.
  - `core_rst_n` and `load_done` drop on the same edge.
  - `overflow` is cleared.
  - `reload` has priority over a same-cycle handshake: the beat is not accepted (`s_ready` is forced to 0 while `reload` = 1) and nothing is written.
- `s_ready` is a function of state and `reload` only; it must not depend on `s_valid`.
- Gaps in `s_valid` are legal. Words are packed contiguously regardless of gaps.
- A zero-length program is not supported; the minimum load is one word with `s_last`.
- Instruction memory contents are never cleared by this block. A `rst_n` assertion mid-load leaves partially written memory in place; the core stays in reset until a full load completes.

## Timing
- Handshake at edge k: `imem_we` is high during cycle k+1, and memory captures the word at edge k+1.
- Back-to-back handshakes produce `imem_we` high on consecutive cycles, one word per cycle sustained.
- Last handshake at edge k:
  - HOLD from edge k.
  - `core_rst_n` rises at edge k+1+RELEASE_DELAY, after the final memory write completes.
  - `load_done` rises on the same edge.
- `reload` sampled at edge r: `core_rst_n` = 0 and `s_ready` = 1 after edge r.
- All outputs are registered except `s_ready`, which is decoded from the state register.

## Structure
- Add the state enum `loader_state_e` (LOAD, HOLD, RUN, ERR) to the shared `defines` package.
- Delay counter width is $clog2(RELEASE_DELAY+1).
- No sub-modules; one FSM with a pointer and a counter.
- Top-level integration: `imem_loader` drives the write port of the instruction memory, and `core_rst_n` drives `core.rst_n`.

## Test plan
- Stream 22 words, back-to-back, with `s_last` on word 21 (RELEASE_DELAY=2) → memory[0..21] match the image, word_count=22, `core_rst_n` rises exactly 3 edges after the last handshake, then the existing stress-program register/memory checks pass.
- Random `s_valid` gaps (~50% duty) on an 8-word program → memory[0..7] are contiguous and correct, and `imem_we` pulses exactly 8 times.
- IMEM_DEPTH=4, stream 5 words with no `s_last` → words 0..3 written, `overflow`=1, state ERR, `s_ready`=0, `core_rst_n` stays 0. A following `reload` clears `overflow`.
- From RUN, pulse `reload`, then load 3 new words → `core_rst_n` drops the next edge, memory[0..2] are updated, memory[3..] are unchanged, RUN is re-entered.
- `reload` in the same cycle as a valid beat carrying 0xDEADBEEF → no write occurs, word_count=0, and the next beat lands at address 0.
- Assert `rst_n` after 3 of 6 words → all outputs return to reset values. Reload 6 words → memory[0..5] are correct and the core is released.
